// File: rtl/cmd_host_pkg.sv
`default_nettype none
// ============================================================================
// Module   : cmd_host_pkg
// Purpose  : Shared definitions for the host-side command initiator.
//            Command target field location, known target codes, host
//            status codes and the cmd_host state encoding.
// Ports    : none (package)
// Revision : 1.0 - initial release
// ============================================================================
package cmd_host_pkg;

    // Target field of a 32-bit command word.
    localparam int C_TARGET_MSB = 31;
    localparam int C_TARGET_LSB = 28;
    localparam int C_TARGET_W   = C_TARGET_MSB - C_TARGET_LSB + 1;

    // Targets served by the executor on the far side of the FIFO pair.
    localparam logic [C_TARGET_W-1:0] C_TARGET_TAP = 4'h1;
    localparam logic [C_TARGET_W-1:0] C_TARGET_PHF = 4'h2;

    // Status codes returned alongside every host response.
    localparam logic [1:0] C_HST_OK      = 2'd0;
    localparam logic [1:0] C_HST_TO_WR   = 2'd1;
    localparam logic [1:0] C_HST_TO_RSP  = 2'd2;
    localparam logic [1:0] C_HST_BAD_TGT = 2'd3;

    // cmd_host state encoding.
    localparam logic [1:0] S_IDLE     = 2'd0;
    localparam logic [1:0] S_WR_CMD   = 2'd1;
    localparam logic [1:0] S_WAIT_RSP = 2'd2;
    localparam logic [1:0] S_DONE     = 2'd3;

    // True when the executor knows how to handle the given target.
    function automatic logic target_known(input logic [C_TARGET_W-1:0] tgt);
        return (tgt == C_TARGET_TAP) || (tgt == C_TARGET_PHF);
    endfunction

endpackage
`default_nettype wire

// File: rtl/cmd_timer.sv
`default_nettype none
// ============================================================================
// Module   : cmd_timer
// Purpose  : Per-phase wait timer. Counts enabled cycles from a clear and
//            flags the terminal count TIMEOUT_CYCLES-1. Holds at terminal
//            count so it can never wrap.
// Ports    : clk, rst_n  - clock, asynchronous active-low reset
//            clr         - synchronous clear (priority over en)
//            en          - count enable
//            tc          - high while count == TIMEOUT_CYCLES-1
// Revision : 1.0 - initial release
// ============================================================================
module cmd_timer #(
    parameter int TIMEOUT_CYCLES = 1024
) (
    input  logic clk,
    input  logic rst_n,
    input  logic clr,
    input  logic en,
    output logic tc
);

    localparam int c_timer_w = (TIMEOUT_CYCLES > 2) ? $clog2(TIMEOUT_CYCLES) : 1;
    localparam logic [c_timer_w-1:0] c_term = c_timer_w'(TIMEOUT_CYCLES - 1);
    localparam logic [c_timer_w-1:0] c_one  = c_timer_w'(1);

    logic [c_timer_w-1:0] r_count;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_count <= '0;
        end else if (clr) begin
            r_count <= '0;
        end else if (en && !tc) begin
            r_count <= r_count + c_one;
        end
    end

    assign tc = (r_count == c_term);

endmodule
`default_nettype wire

// File: rtl/cmd_host.sv
`default_nettype none
// ============================================================================
// Module   : cmd_host
// Purpose  : Host-side initiator for the command/response FIFO pair.
//            Takes one command at a time from the host, writes it into the
//            cmd FIFO, waits for the matching response in the rsp FIFO and
//            hands it back with a status code. Unknown targets are rejected
//            locally, both wait phases time out, and any response left over
//            from a timed-out command is drained while idle.
// Ports    : clk, rst_n                         - clock, async active-low reset
//            host_cmd_data/valid/ready          - host command port
//            host_rsp_data/status/valid/ready   - host response port
//            cmd_wrdata, cmd_wrreq, cmd_wr_waitreq - cmd FIFO write side
//            rsp_rddata, rsp_rdreq, rsp_rd_waitreq - rsp FIFO show-ahead read
//            stale_cnt                          - saturating drained-response count
//            busy                               - high whenever not idle
// Revision : 1.0 - initial release
// ============================================================================
module cmd_host
    import cmd_host_pkg::*;
#(
    parameter int TIMEOUT_CYCLES = 1024,
    parameter int STALE_W        = 8
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic [31:0]        host_cmd_data,
    input  logic               host_cmd_valid,
    output logic               host_cmd_ready,
    output logic [31:0]        host_rsp_data,
    output logic [1:0]         host_rsp_status,
    output logic               host_rsp_valid,
    input  logic               host_rsp_ready,
    output logic [31:0]        cmd_wrdata,
    output logic               cmd_wrreq,
    input  logic               cmd_wr_waitreq,
    input  logic [31:0]        rsp_rddata,
    output logic               rsp_rdreq,
    input  logic               rsp_rd_waitreq,
    output logic [STALE_W-1:0] stale_cnt,
    output logic               busy
);

    localparam logic [STALE_W-1:0] c_stale_max = '1;
    localparam logic [STALE_W-1:0] c_stale_one = STALE_W'(1);

    logic [1:0]         r_state;
    logic [1:0]         w_state_next;
    logic [31:0]        r_cmd_data;
    logic [31:0]        w_cmd_data_next;
    logic [31:0]        r_rsp_data;
    logic [31:0]        w_rsp_data_next;
    logic [1:0]         r_status;
    logic [1:0]         w_status_next;
    logic [STALE_W-1:0] r_stale;
    logic [STALE_W-1:0] w_stale_next;
    // Low only until the first clock after reset; keeps the combinational
    // handshake strobes at 0 while the block is held in reset.
    logic               r_run;
    logic               w_timer_clr;
    logic               w_timer_en;
    logic               w_timer_tc;

    cmd_timer #(
        .TIMEOUT_CYCLES (TIMEOUT_CYCLES)
    ) u_timer (
        .clk   (clk),
        .rst_n (rst_n),
        .clr   (w_timer_clr),
        .en    (w_timer_en),
        .tc    (w_timer_tc)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state    <= S_IDLE;
            r_cmd_data <= '0;
            r_rsp_data <= '0;
            r_status   <= C_HST_OK;
            r_stale    <= '0;
            r_run      <= 1'b0;
        end else begin
            r_state    <= w_state_next;
            r_cmd_data <= w_cmd_data_next;
            r_rsp_data <= w_rsp_data_next;
            r_status   <= w_status_next;
            r_stale    <= w_stale_next;
            r_run      <= 1'b1;
        end
    end

    always_comb begin
        w_state_next    = r_state;
        w_cmd_data_next = r_cmd_data;
        w_rsp_data_next = r_rsp_data;
        w_status_next   = r_status;
        w_stale_next    = r_stale;
        w_timer_en      = 1'b0;
        host_cmd_ready  = 1'b0;
        host_rsp_valid  = 1'b0;
        cmd_wrreq       = 1'b0;
        rsp_rdreq       = 1'b0;

        case (r_state)
            S_IDLE: begin
                if (r_run) begin
                    // Any response sitting in the FIFO while idle belongs to
                    // a command that already timed out: throw it away before
                    // a new command can be paired with it.
                    host_cmd_ready = rsp_rd_waitreq;
                    if (!rsp_rd_waitreq) begin
                        rsp_rdreq = 1'b1;
                        if (r_stale != c_stale_max) begin
                            w_stale_next = r_stale + c_stale_one;
                        end
                    end else if (host_cmd_valid) begin
                        w_cmd_data_next = host_cmd_data;
                        if (target_known(host_cmd_data[C_TARGET_MSB:C_TARGET_LSB])) begin
                            w_state_next = S_WR_CMD;
                        end else begin
                            w_state_next    = S_DONE;
                            w_status_next   = C_HST_BAD_TGT;
                            w_rsp_data_next = '0;
                        end
                    end
                end
            end

            S_WR_CMD: begin
                cmd_wrreq = !cmd_wr_waitreq;
                // A write in the terminal-count cycle still goes through.
                if (!cmd_wr_waitreq) begin
                    w_state_next = S_WAIT_RSP;
                end else if (w_timer_tc) begin
                    w_state_next    = S_DONE;
                    w_status_next   = C_HST_TO_WR;
                    w_rsp_data_next = '0;
                end else begin
                    w_timer_en = 1'b1;
                end
            end

            S_WAIT_RSP: begin
                rsp_rdreq = !rsp_rd_waitreq;
                // A response in the terminal-count cycle still counts as OK.
                if (!rsp_rd_waitreq) begin
                    w_state_next    = S_DONE;
                    w_status_next   = C_HST_OK;
                    w_rsp_data_next = rsp_rddata;
                end else if (w_timer_tc) begin
                    w_state_next    = S_DONE;
                    w_status_next   = C_HST_TO_RSP;
                    w_rsp_data_next = '0;
                end else begin
                    w_timer_en = 1'b1;
                end
            end

            S_DONE: begin
                host_rsp_valid = 1'b1;
                if (host_rsp_ready) begin
                    w_state_next = S_IDLE;
                end
            end

            default: begin
                w_state_next = S_IDLE;
            end
        endcase
    end

    // Every state entry restarts the wait timer.
    assign w_timer_clr     = (w_state_next != r_state);

    assign cmd_wrdata      = r_cmd_data;
    assign host_rsp_data   = r_rsp_data;
    assign host_rsp_status = r_status;
    assign stale_cnt       = r_stale;
    assign busy            = (r_state != S_IDLE);

endmodule
`default_nettype wire

// File: tb/tb_cmd_host.sv
`default_nettype none
// ============================================================================
// Module   : tb_cmd_host
// Purpose  : Self-checking bench for cmd_host. Models the cmd FIFO (full
//            flag) and a show-ahead rsp FIFO, and predicts each command's
//            status, data, strobe counts and latency from the protocol rules.
// Ports    : none
// Revision : 1.0 - initial release
// ============================================================================
module tb_cmd_host;
    import cmd_host_pkg::*;

    localparam int T  = 16;
    localparam int SW = 8;

    logic          clk = 1'b0;
    logic          rst_n = 1'b0;
    logic [31:0]   host_cmd_data = '0;
    logic          host_cmd_valid = 1'b0;
    logic          host_cmd_ready;
    logic [31:0]   host_rsp_data;
    logic [1:0]    host_rsp_status;
    logic          host_rsp_valid;
    logic          host_rsp_ready = 1'b0;
    logic [31:0]   cmd_wrdata;
    logic          cmd_wrreq;
    logic          cmd_wr_waitreq = 1'b0;
    logic [31:0]   rsp_rddata = 32'hDEADBEEF;
    logic          rsp_rdreq;
    logic          rsp_rd_waitreq = 1'b1;
    logic [SW-1:0] stale_cnt;
    logic          busy;

    cmd_host #(.TIMEOUT_CYCLES(T), .STALE_W(SW)) dut (
        .clk(clk), .rst_n(rst_n),
        .host_cmd_data(host_cmd_data), .host_cmd_valid(host_cmd_valid),
        .host_cmd_ready(host_cmd_ready),
        .host_rsp_data(host_rsp_data), .host_rsp_status(host_rsp_status),
        .host_rsp_valid(host_rsp_valid), .host_rsp_ready(host_rsp_ready),
        .cmd_wrdata(cmd_wrdata), .cmd_wrreq(cmd_wrreq), .cmd_wr_waitreq(cmd_wr_waitreq),
        .rsp_rddata(rsp_rddata), .rsp_rdreq(rsp_rdreq), .rsp_rd_waitreq(rsp_rd_waitreq),
        .stale_cnt(stale_cnt), .busy(busy)
    );

    always #5 clk = ~clk;

    int checks = 0;
    int failures = 0;
    int cyc = 0;
    int exp_stale = 0;

    logic [31:0] rsp_q[$];
    bit          pend = 1'b0;
    int          pend_at = 0;
    logic [31:0] pend_data = '0;

    bit          s_ready, s_wrreq, s_rdreq, s_rvalid;
    logic [31:0] s_wrdata, s_rdata;
    logic [1:0]  s_status;

    task automatic fifo_drive();
        rsp_rd_waitreq = (rsp_q.size() == 0);
        rsp_rddata     = (rsp_q.size() != 0) ? rsp_q[0] : 32'hDEADBEEF;
    endtask

    // One clock: sample at the falling edge, then update the FIFO model
    // just after the rising edge.
    task automatic tick();
        @(negedge clk);
        s_ready = host_cmd_ready; s_wrreq = cmd_wrreq; s_rdreq = rsp_rdreq;
        s_rvalid = host_rsp_valid; s_wrdata = cmd_wrdata;
        s_rdata = host_rsp_data; s_status = host_rsp_status;
        if (s_wrreq) begin
            checks++;
            if (cmd_wr_waitreq !== 1'b0) begin
                failures++; $display("FAIL wrreq_while_full: waitreq=%b required 0", cmd_wr_waitreq);
            end
        end
        if (s_rdreq) begin
            checks++;
            if (rsp_rd_waitreq !== 1'b0) begin
                failures++; $display("FAIL rdreq_while_empty: waitreq=%b required 0", rsp_rd_waitreq);
            end
        end
        @(posedge clk); #1;
        cyc++;
        if (s_rdreq && rsp_q.size() > 0) void'(rsp_q.pop_front());
        if (pend && cyc >= pend_at) begin rsp_q.push_back(pend_data); pend = 1'b0; end
        fifo_drive();
    endtask

    // Reference outcome of one command. w = cycles the cmd FIFO stays full
    // from the first write opportunity, d = cycles the response arrives
    // after the write.
    function automatic void model(input logic [31:0] cmd, input int w, input int d,
                                  input logic [31:0] rword,
                                  output logic [1:0] st, output logic [31:0] data,
                                  output int nwr, output int npop, output int lat,
                                  output bit late);
        logic [3:0] tgt;
        tgt = cmd[31:28];
        nwr = 0; npop = 0; data = '0; late = 1'b0;
        if (!(tgt == 4'h1 || tgt == 4'h2)) begin
            st = 2'd3; lat = 1;
        end else if (w >= T) begin
            st = 2'd1; lat = 1 + T;
        end else begin
            nwr = 1;
            if (d <= T - 1) begin
                st = 2'd0; data = rword; npop = 1; lat = 3 + w + d;
            end else begin
                st = 2'd2; lat = 2 + w + T; late = 1'b1;
            end
        end
    endfunction

    // Drives one command through to the response handshake.
    task automatic run_txn(input logic [31:0] cmd, input int w, input int d,
                           input logic [31:0] rword, input int hold,
                           output int nwr, output logic [31:0] wr_word, output int npop,
                           output logic [31:0] got_data, output logic [1:0] got_status,
                           output int lat, output bit stable_ok, output bit done);
        int phase = 0, c_acc = 0, hcnt = 0;
        nwr = 0; npop = 0; wr_word = '0; got_data = '0; got_status = '0; lat = -1;
        stable_ok = 1'b1; done = 1'b0;
        host_cmd_data = cmd; host_cmd_valid = 1'b1; host_rsp_ready = 1'b0;
        cmd_wr_waitreq = (w > 0);
        for (int n = 0; n < 300 && !done; n++) begin
            tick();
            case (phase)
                0: if (s_ready) begin
                       c_acc = cyc - 1; phase = 1;
                       host_cmd_valid = 1'b0; host_cmd_data = $urandom;
                   end
                1: begin
                       if (s_rdreq) npop++;
                       if (s_wrreq) begin
                           nwr++; wr_word = s_wrdata;
                           pend = 1'b1; pend_at = cyc + d; pend_data = rword;
                           if (pend_at <= cyc) begin rsp_q.push_back(rword); pend = 1'b0; fifo_drive(); end
                           cmd_wr_waitreq = 1'b0;
                       end else if (nwr == 0) begin
                           cmd_wr_waitreq = ((cyc - (c_acc + 1)) < w);
                       end
                       if (s_rvalid) begin
                           got_data = s_rdata; got_status = s_status; lat = (cyc - 1) - c_acc;
                           cmd_wr_waitreq = 1'b0;
                           if (hold == 0) begin host_rsp_ready = 1'b1; phase = 3; end
                           else phase = 2;
                       end
                   end
                2: begin
                       if (!s_rvalid || s_rdata !== got_data || s_status !== got_status || s_wrreq || s_rdreq)
                           stable_ok = 1'b0;
                       hcnt++;
                       if (hcnt >= hold) begin host_rsp_ready = 1'b1; phase = 3; end
                   end
                3: begin
                       if (!s_rvalid || s_wrreq || s_rdreq) stable_ok = 1'b0;
                       host_rsp_ready = 1'b0; phase = 4;
                   end
                default: begin
                       if (s_rvalid) stable_ok = 1'b0;
                       done = 1'b1;
                   end
            endcase
        end
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        repeat (2) @(negedge clk);
        checks++;
        if ({busy, host_rsp_valid, host_cmd_ready, cmd_wrreq, rsp_rdreq, cmd_wrdata,
             host_rsp_data, host_rsp_status, stale_cnt} !== '0) begin
            failures++;
            $display("FAIL reset_outputs: busy=%b valid=%b ready=%b wrdata=%h data=%h st=%0d stale=%0d required all 0",
                     busy, host_rsp_valid, host_cmd_ready, cmd_wrdata, host_rsp_data, host_rsp_status, stale_cnt);
        end
        rst_n = 1'b1;
        tick(); tick();
        checks++;
        if (host_cmd_ready !== 1'b1 || busy !== 1'b0) begin
            failures++; $display("FAIL idle_after_reset: ready=%b busy=%b required 1/0", host_cmd_ready, busy);
        end
    endtask

    task automatic test_tap();
        logic [31:0] cmd, wrw, gd; logic [1:0] gs; int nwr, npop, lat; bit st_ok, done;
        cmd = {C_TARGET_TAP, 28'h0000012};
        run_txn(cmd, 0, 2, 32'hCAFE0001, 0, nwr, wrw, npop, gd, gs, lat, st_ok, done);
        checks++; if (!done) begin failures++; $display("FAIL tap_done: transaction did not finish, required finish"); end
        checks++; if (nwr != 1 || wrw !== cmd) begin failures++; $display("FAIL tap_write: n=%0d word=%h required 1/%h", nwr, wrw, cmd); end
        checks++; if (npop != 1) begin failures++; $display("FAIL tap_pop: n=%0d required 1", npop); end
        checks++; if (gd !== 32'hCAFE0001 || gs !== C_HST_OK) begin failures++; $display("FAIL tap_rsp: data=%h st=%0d required cafe0001/0", gd, gs); end
        checks++; if (lat != 5) begin failures++; $display("FAIL tap_latency: %0d required 5", lat); end
    endtask

    task automatic test_timeout_wr();
        logic [31:0] wrw, gd; logic [1:0] gs; int nwr, npop, lat; bit st_ok, done;
        run_txn({C_TARGET_PHF, 28'h0ABCDEF}, T + 5, 0, 32'h1, 0, nwr, wrw, npop, gd, gs, lat, st_ok, done);
        checks++; if (!done || nwr != 0) begin failures++; $display("FAIL towr_nowrite: done=%b n=%0d required 1/0", done, nwr); end
        checks++; if (gs !== C_HST_TO_WR || gd !== 32'h0) begin failures++; $display("FAIL towr_rsp: data=%h st=%0d required 0/1", gd, gs); end
        checks++; if (lat != T + 1) begin failures++; $display("FAIL towr_latency: %0d required %0d", lat, T + 1); end
    endtask

    task automatic test_bad_target();
        logic [31:0] wrw, gd; logic [1:0] gs; int nwr, npop, lat; bit st_ok, done;
        run_txn(32'h7000_0055, 0, 0, 32'h2, 0, nwr, wrw, npop, gd, gs, lat, st_ok, done);
        checks++; if (!done || nwr != 0) begin failures++; $display("FAIL bad_nowrite: done=%b n=%0d required 1/0", done, nwr); end
        checks++; if (gs !== C_HST_BAD_TGT || gd !== 32'h0) begin failures++; $display("FAIL bad_rsp: data=%h st=%0d required 0/3", gd, gs); end
        checks++; if (lat != 1) begin failures++; $display("FAIL bad_latency: %0d required 1", lat); end
    endtask

    task automatic test_timeout_rsp();
        logic [31:0] wrw, gd; logic [1:0] gs; int nwr, npop, lat; bit st_ok, done;
        run_txn({C_TARGET_TAP, 28'h0000033}, 0, T + 4, 32'hBAD0BAD0, 0, nwr, wrw, npop, gd, gs, lat, st_ok, done);
        checks++; if (gs !== C_HST_TO_RSP || gd !== 32'h0 || npop != 0) begin
            failures++; $display("FAIL torsp_rsp: data=%h st=%0d pops=%0d required 0/2/0", gd, gs, npop); end
        checks++; if (lat != 2 + T) begin failures++; $display("FAIL torsp_latency: %0d required %0d", lat, 2 + T); end
        for (int n = 0; n < 40 && rsp_rd_waitreq; n++) tick();
        host_cmd_data = {C_TARGET_PHF, 28'h0000044}; host_cmd_valid = 1'b1;
        tick();
        exp_stale++;
        checks++; if (s_ready !== 1'b0 || s_rdreq !== 1'b1) begin
            failures++; $display("FAIL stale_drain: ready=%b rdreq=%b required 0/1", s_ready, s_rdreq); end
        checks++; if (stale_cnt !== SW'(exp_stale)) begin failures++; $display("FAIL stale_cnt1: %0d required %0d", stale_cnt, exp_stale); end
        run_txn({C_TARGET_PHF, 28'h0000044}, 0, 1, 32'h600D0002, 0, nwr, wrw, npop, gd, gs, lat, st_ok, done);
        checks++; if (gd !== 32'h600D0002 || gs !== C_HST_OK) begin failures++; $display("FAIL after_stale_rsp: data=%h st=%0d required 600d0002/0", gd, gs); end
    endtask

    task automatic test_rsp_at_timeout();
        logic [31:0] wrw, gd; logic [1:0] gs; int nwr, npop, lat; bit st_ok, done;
        run_txn({C_TARGET_PHF, 28'h0000077}, 2, T - 1, 32'h12345678, 5, nwr, wrw, npop, gd, gs, lat, st_ok, done);
        checks++; if (gd !== 32'h12345678 || gs !== C_HST_OK) begin failures++; $display("FAIL edge_rsp: data=%h st=%0d required 12345678/0", gd, gs); end
        checks++; if (lat != 3 + 2 + T - 1) begin failures++; $display("FAIL edge_latency: %0d required %0d", lat, 4 + T); end
        checks++; if (!st_ok || !done) begin failures++; $display("FAIL hold_stable: stable=%b done=%b required 1/1", st_ok, done); end
    endtask

    task automatic test_random();
        logic [31:0] cmd, rword, wrw, gd, ed; logic [1:0] gs, es;
        int w, d, hold, nwr, npop, lat, enwr, enpop, elat; bit st_ok, done, late;
        logic [3:0] tgts [3];
        tgts[0] = C_TARGET_TAP; tgts[1] = C_TARGET_PHF; tgts[2] = 4'hB;
        for (int i = 0; i < 20; i++) begin
            cmd   = {tgts[$urandom_range(0, 2)], 28'($urandom)};
            w     = $urandom_range(0, T + 2);
            d     = $urandom_range(0, T + 2);
            hold  = $urandom_range(0, 3);
            rword = $urandom;
            model(cmd, w, d, rword, es, ed, enwr, enpop, elat, late);
            run_txn(cmd, w, d, rword, hold, nwr, wrw, npop, gd, gs, lat, st_ok, done);
            checks++;
            if (!done || gs !== es || gd !== ed) begin
                failures++; $display("FAIL rnd%0d_rsp: done=%b st=%0d data=%h required st=%0d data=%h", i, done, gs, gd, es, ed); end
            checks++;
            if (nwr != enwr || npop != enpop || (nwr == 1 && wrw !== cmd)) begin
                failures++; $display("FAIL rnd%0d_strobes: wr=%0d pop=%0d word=%h required %0d/%0d/%h", i, nwr, npop, wrw, enwr, enpop, cmd); end
            checks++;
            if (lat != elat || !st_ok) begin
                failures++; $display("FAIL rnd%0d_timing: lat=%0d stable=%b required %0d/1", i, lat, st_ok, elat); end
            if (late) exp_stale++;
            for (int n = 0; n < 3 * T && (pend || rsp_q.size() != 0); n++) tick();
        end
        tick();
        checks++; if (stale_cnt !== SW'(exp_stale)) begin failures++; $display("FAIL rnd_stale: %0d required %0d", stale_cnt, exp_stale); end
    endtask

    task automatic test_reset_midop();
        logic [31:0] cmd;
        cmd = {C_TARGET_TAP, 28'h0000099};
        host_cmd_data = cmd; host_cmd_valid = 1'b1; cmd_wr_waitreq = 1'b0;
        for (int n = 0; n < 20; n++) begin
            tick();
            if (s_ready) host_cmd_valid = 1'b0;
            if (s_wrreq) break;
        end
        tick(); tick();
        checks++; if (busy !== 1'b1 || cmd_wrdata !== cmd) begin failures++; $display("FAIL midop_pre: busy=%b wrdata=%h required 1/%h", busy, cmd_wrdata, cmd); end
        #2 rst_n = 1'b0;
        #1;
        checks++;
        if ({busy, host_rsp_valid, host_cmd_ready, cmd_wrreq, rsp_rdreq, cmd_wrdata,
             host_rsp_data, host_rsp_status, stale_cnt} !== '0) begin
            failures++;
            $display("FAIL midop_reset: busy=%b ready=%b wrdata=%h data=%h st=%0d stale=%0d required all 0",
                     busy, host_cmd_ready, cmd_wrdata, host_rsp_data, host_rsp_status, stale_cnt);
        end
        rsp_q.delete(); pend = 1'b0; exp_stale = 0; fifo_drive();
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        tick(); tick();
    endtask

    task automatic test_stale_saturate();
        for (int i = 0; i < 300; i++) rsp_q.push_back(32'($urandom));
        fifo_drive();
        for (int n = 0; n < 400 && rsp_q.size() != 0; n++) tick();
        tick();
        checks++; if (rsp_q.size() != 0) begin failures++; $display("FAIL sat_drained: left=%0d required 0", rsp_q.size()); end
        checks++; if (stale_cnt !== 8'd255) begin failures++; $display("FAIL sat_stale: %0d required 255", stale_cnt); end
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        fifo_drive();
        test_reset();
        test_tap();
        test_timeout_wr();
        test_bad_target();
        test_timeout_rsp();
        test_rsp_at_timeout();
        test_random();
        test_reset_midop();
        test_stale_saturate();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
`default_nettype wire
